// File: rtl/life_sched_pkg.sv
// Shared types and constants for the 8x8 life array sequencer.
// Tile selector order matches the array's vali/valo selector inputs.
package life_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        READ = 2'd3
    } sched_state_t;

    typedef enum logic {
        GRANT_STEP = 1'b0,
        GRANT_READ = 1'b1
    } grant_t;

    localparam logic [1:0] TILE_NW = 2'd0;
    localparam logic [1:0] TILE_SW = 2'd1;
    localparam logic [1:0] TILE_NE = 2'd2;
    localparam logic [1:0] TILE_SE = 2'd3;

    localparam int unsigned TILE_BITS = 16;

    // Round-robin between a pending step and a reader: the requester not
    // served last wins a tie; a lone requester always wins.
    function automatic logic step_wins(input grant_t last, input logic rd_ok);
        return !rd_ok || (last == GRANT_READ);
    endfunction

endpackage

// File: rtl/life_sched_8x8_timer.sv
// Generation timer: period down-counter, single_step edge detect and the
// single merged step_pending flag.
module life_step_timer
    import life_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    input  logic                single_step,
    input  logic                clr_pending,
    output logic                step_pending
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                ss_q;
    logic                pend_q, pend_d;
    logic                tick;
    logic                ss_rise;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (run && (period != '0)) begin
            if (cnt_q == '0) begin
                tick  = 1'b1;
                cnt_d = period - PERIOD_W'(1);
            end else begin
                cnt_d = cnt_q - PERIOD_W'(1);
            end
        end
    end

    assign ss_rise = single_step && !ss_q;

    // A new request in the clearing cycle must survive, so set wins.
    always_comb begin
        pend_d = pend_q;
        if (tick || ss_rise) begin
            pend_d = 1'b1;
        end else if (clr_pending) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            ss_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ss_q   <= single_step;
            pend_q <= pend_d;
        end
    end

    assign step_pending = pend_q;

endmodule

// File: rtl/life_sched_8x8.sv
// Sequencer/arbiter sharing the life array's write port, step strobe and
// readout mux between the loader, the generation timer and the tile reader.
module life_sched_8x8
    import life_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned GEN_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                single_step,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load_req,
    input  logic [1:0]          load_tile,
    input  logic [15:0]         load_data,
    output logic                load_ack,
    input  logic                rd_req,
    input  logic [1:0]          rd_tile,
    output logic                rd_ack,
    output logic [15:0]         rd_data,
    output logic [15:0]         arr_vali,
    output logic [1:0]          arr_vali_sel,
    output logic                arr_write_enb,
    output logic                arr_step,
    output logic [1:0]          arr_valo_sel,
    input  logic [15:0]         arr_valo,
    output logic [GEN_W-1:0]    gen_count,
    output logic                busy
);

    sched_state_t     state_q;
    grant_t           last_grant_q;
    logic             load_ack_q;
    logic             rd_ack_q;
    logic [15:0]      rd_data_q;
    logic [15:0]      arr_vali_q;
    logic [1:0]       arr_vali_sel_q;
    logic             arr_write_enb_q;
    logic             arr_step_q;
    logic [1:0]       arr_valo_sel_q;
    logic [GEN_W-1:0] gen_q;

    logic step_pending;
    logic clr_pending;
    logic rd_ok;

    assign clr_pending = (state_q == STEP);
    // The reader still holds rd_req in its ack cycle; that is not a new request.
    assign rd_ok       = rd_req && !rd_ack_q;

    life_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .period       (period),
        .single_step  (single_step),
        .clr_pending  (clr_pending),
        .step_pending (step_pending)
    );

    // Strobes are set on the transition into their state so they are high
    // for exactly the one cycle spent in LOAD/STEP/READ(+1 for rd_ack).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            last_grant_q    <= GRANT_READ;
            load_ack_q      <= 1'b0;
            rd_ack_q        <= 1'b0;
            rd_data_q       <= '0;
            arr_vali_q      <= '0;
            arr_vali_sel_q  <= '0;
            arr_write_enb_q <= 1'b0;
            arr_step_q      <= 1'b0;
            arr_valo_sel_q  <= '0;
            gen_q           <= '0;
        end else begin
            load_ack_q      <= 1'b0;
            rd_ack_q        <= 1'b0;
            arr_write_enb_q <= 1'b0;
            arr_step_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_req) begin
                        state_q         <= LOAD;
                        arr_vali_q      <= load_data;
                        arr_vali_sel_q  <= load_tile;
                        arr_write_enb_q <= 1'b1;
                        load_ack_q      <= 1'b1;
                    end else if (step_pending && step_wins(last_grant_q, rd_ok)) begin
                        state_q      <= STEP;
                        arr_step_q   <= 1'b1;
                        last_grant_q <= GRANT_STEP;
                    end else if (rd_ok) begin
                        state_q        <= READ;
                        arr_valo_sel_q <= rd_tile;
                        last_grant_q   <= GRANT_READ;
                    end
                end
                LOAD: begin
                    gen_q   <= '0;
                    state_q <= IDLE;
                end
                STEP: begin
                    if (gen_q != '1) begin
                        gen_q <= gen_q + GEN_W'(1);
                    end
                    state_q <= IDLE;
                end
                READ: begin
                    rd_data_q <= arr_valo;
                    rd_ack_q  <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ack      = load_ack_q;
    assign rd_ack        = rd_ack_q;
    assign rd_data       = rd_data_q;
    assign arr_vali      = arr_vali_q;
    assign arr_vali_sel  = arr_vali_sel_q;
    assign arr_write_enb = arr_write_enb_q;
    assign arr_step      = arr_step_q;
    assign arr_valo_sel  = arr_valo_sel_q;
    assign gen_count     = gen_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_life_sched_8x8.sv
// Self-checking bench for life_sched_8x8: table-driven loads/reads, directed
// multi-cycle corner cases and a randomized phase against a scoreboard.
module tb_life_sched_8x8;
    import life_sched_pkg::*;

    localparam int unsigned PW = 24;
    localparam int unsigned GW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          single_step = 1'b0;
    logic [PW-1:0] period = '0;
    logic          load_req = 1'b0;
    logic [1:0]    load_tile = '0;
    logic [15:0]   load_data = '0;
    logic          rd_req = 1'b0;
    logic [1:0]    rd_tile = '0;

    logic          load_ack, rd_ack, arr_write_enb, arr_step, busy;
    logic [15:0]   rd_data, arr_vali, arr_valo;
    logic [1:0]    arr_vali_sel, arr_valo_sel;
    logic [GW-1:0] gen_count;

    // Behavioural stand-in for the life array's tile storage.
    logic [15:0] mem [4] = '{default: '0};
    assign arr_valo = mem[arr_valo_sel];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_step = 0, n_write = 0, n_lack = 0;
    int step_cyc = 0, write_cyc = 0;
    logic [15:0] shadow [4] = '{default: '0};

    typedef struct {
        logic        is_rd;
        logic [1:0]  tile;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    life_sched_8x8 #(.PERIOD_W(PW), .GEN_W(GW)) dut (
        .clk(clk), .reset(reset), .run(run), .single_step(single_step),
        .period(period), .load_req(load_req), .load_tile(load_tile),
        .load_data(load_data), .load_ack(load_ack), .rd_req(rd_req),
        .rd_tile(rd_tile), .rd_ack(rd_ack), .rd_data(rd_data),
        .arr_vali(arr_vali), .arr_vali_sel(arr_vali_sel),
        .arr_write_enb(arr_write_enb), .arr_step(arr_step),
        .arr_valo_sel(arr_valo_sel), .arr_valo(arr_valo),
        .gen_count(gen_count), .busy(busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance one clock, sample 1ns after the edge, keep the array model and strobe tallies.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("strobe_exclusive", 32'(arr_write_enb & arr_step), 32'd0);
        if (arr_write_enb) begin
            mem[arr_vali_sel] = arr_vali;
            n_write++;
            write_cyc = cyc;
        end
        if (arr_step) begin
            n_step++;
            step_cyc = cyc;
        end
        if (load_ack) n_lack++;
    endtask

    task automatic do_load(input logic [1:0] t, input logic [15:0] d);
        bit got;
        got = 1'b0;
        load_req = 1'b1; load_tile = t; load_data = d;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (load_ack) got = 1'b1;
        end
        load_req = 1'b0;
        check("load_ack_seen", 32'(got), 32'd1);
        if (got) begin
            check("load_we", 32'(arr_write_enb), 32'd1);
            check("load_vali_sel", 32'(arr_vali_sel), 32'(t));
            check("load_vali", 32'(arr_vali), 32'(d));
            shadow[t] = d;
        end
    endtask

    task automatic do_read(input logic [1:0] t, input logic [15:0] exp);
        bit got;
        got = 1'b0;
        rd_req = 1'b1; rd_tile = t;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (rd_ack) got = 1'b1;
        end
        rd_req = 1'b0;
        check("rd_ack_seen", 32'(got), 32'd1);
        if (got) begin
            check("rd_valo_sel", 32'(arr_valo_sel), 32'(t));
            check("rd_data", 32'(rd_data), 32'(exp));
        end
    endtask

    task automatic pulse_step();
        single_step = 1'b1;
        tick();
        single_step = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        vec_t vecs [8];
        int   base_step, base_lack, base_write, last_i, nacks, steps_since, nl, wc, sc;
        int   gen_exp;
        bit   seen_w, seen_s;

        vecs[0] = '{1'b0, TILE_NW, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, TILE_SW, 16'h0660, 16'h0660};
        vecs[2] = '{1'b0, TILE_NE, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, TILE_SE, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, TILE_NW, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, TILE_SW, 16'h0000, 16'h0660};
        vecs[6] = '{1'b1, TILE_NE, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, TILE_SE, 16'h0000, 16'h0000};

        // Reset state
        tick(); tick();
        check("rst_load_ack", 32'(load_ack), 0);
        check("rst_rd_ack", 32'(rd_ack), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_vali", 32'(arr_vali), 0);
        check("rst_vali_sel", 32'(arr_vali_sel), 0);
        check("rst_we", 32'(arr_write_enb), 0);
        check("rst_step", 32'(arr_step), 0);
        check("rst_valo_sel", 32'(arr_valo_sel), 0);
        check("rst_gen", 32'(gen_count), 0);
        check("rst_busy", 32'(busy), 0);
        #2 reset = 1'b1;
        tick();

        // Reset during the LOAD cycle abandons the load
        pulse_step();
        check("gen_after_single", 32'(gen_count), 32'd1);
        load_req = 1'b1; load_tile = TILE_NE; load_data = 16'hBEEF;
        tick();
        check("midload_in_load", 32'(arr_write_enb), 32'd1);
        reset = 1'b0;
        #1;
        check("midload_we", 32'(arr_write_enb), 0);
        check("midload_ack", 32'(load_ack), 0);
        check("midload_gen", 32'(gen_count), 0);
        check("midload_busy", 32'(busy), 0);
        load_req = 1'b0;
        #3 reset = 1'b1;
        base_lack = n_lack;
        for (int i = 0; i < 5; i++) tick();
        check("midload_no_ack_after", 32'(n_lack - base_lack), 0);

        // Table: four loads, then read each tile back
        base_step = n_step; base_lack = n_lack; base_write = n_write;
        foreach (vecs[k]) begin
            if (!vecs[k].is_rd) do_load(vecs[k].tile, vecs[k].data);
            else                do_read(vecs[k].tile, vecs[k].exp);
        end
        check("table_lack_count", 32'(n_lack - base_lack), 32'd4);
        check("table_write_count", 32'(n_write - base_write), 32'd4);
        check("table_no_step", 32'(n_step - base_step), 0);
        check("table_gen", 32'(gen_count), 0);

        // Free-running, period 10
        base_step = n_step; last_i = -1;
        period = 24'd10; run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (arr_step) begin
                if (last_i >= 0) check("step_interval", 32'(i - last_i), 32'd10);
                last_i = i;
            end
        end
        check("run_gen5", 32'(gen_count), 32'd5);
        check("run_step_count", 32'(n_step - base_step), 32'd5);
        period = '0;
        base_step = n_step;
        for (int i = 0; i < 30; i++) tick();
        check("period0_no_step", 32'(n_step - base_step), 0);
        run = 1'b0;

        // Load and pending step collide: LOAD first, STEP two cycles later
        single_step = 1'b1;
        tick();
        load_req = 1'b1; load_tile = TILE_SE; load_data = 16'h1234;
        seen_w = 1'b0; seen_s = 1'b0; wc = 0; sc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (arr_write_enb) begin seen_w = 1'b1; wc = cyc; end
            if (arr_step)      begin seen_s = 1'b1; sc = cyc; end
            if (load_ack) begin load_req = 1'b0; shadow[TILE_SE] = 16'h1234; end
        end
        single_step = 1'b0;
        check("collide_write_seen", 32'(seen_w), 32'd1);
        check("collide_step_seen", 32'(seen_s), 32'd1);
        check("collide_step_delay", 32'(sc - wc), 32'd2);
        check("collide_gen", 32'(gen_count), 32'd1);

        // Single-step edges during back-to-back loads merge into one step
        base_step = n_step; nl = 0;
        load_req = 1'b1; load_tile = 2'd0; load_data = 16'h00A0;
        for (int i = 0; i < 40 && nl < 6; i++) begin
            single_step = (i >= 1 && i <= 6) ? ((i % 2) == 1) : 1'b0;
            tick();
            if (load_ack) begin
                shadow[load_tile] = load_data;
                nl++;
                if (nl < 6) begin
                    load_tile = 2'(nl % 4);
                    load_data = 16'h00A0 + 16'(nl);
                end else begin
                    load_req = 1'b0;
                end
            end
        end
        single_step = 1'b0;
        check("merge_loads_done", 32'(nl), 32'd6);
        check("merge_no_step_during", 32'(n_step - base_step), 0);
        for (int i = 0; i < 6; i++) tick();
        check("merge_one_step", 32'(n_step - base_step), 32'd1);
        check("merge_gen", 32'(gen_count), 32'd1);

        // period=1 with the reader always requesting: grants alternate
        nacks = 0; steps_since = 0; last_i = -1;
        rd_tile = TILE_SW; rd_req = 1'b1; period = 24'd1; run = 1'b1;
        for (int i = 0; i < 60 && rd_req; i++) begin
            tick();
            if (arr_step) steps_since++;
            if (rd_ack) begin
                check("alt_rd_data", 32'(rd_data), 32'(shadow[TILE_SW]));
                check("alt_rd_gap_le4", 32'((i - last_i) <= 4), 32'd1);
                if (nacks > 0) check("alt_one_step_between", 32'(steps_since), 32'd1);
                steps_since = 0;
                last_i = i;
                nacks++;
                if (nacks == 5) rd_req = 1'b0;
            end
        end
        rd_req = 1'b0; run = 1'b0; period = '0;
        check("alt_ack_count", 32'(nacks), 32'd5);
        for (int i = 0; i < 6; i++) tick();

        // Randomized operations against the scoreboard
        do_load(2'($urandom_range(0, 3)), 16'($urandom));
        gen_exp = 0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    do_load(2'($urandom_range(0, 3)), 16'($urandom));
                    tick();
                    gen_exp = 0;
                end
                1: begin
                    logic [1:0] t;
                    t = 2'($urandom_range(0, 3));
                    do_read(t, shadow[t]);
                end
                default: begin
                    pulse_step();
                    gen_exp++;
                end
            endcase
            check("rand_gen", 32'(gen_count), 32'(gen_exp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_sched_8x8.md
Name: life_sched_8x8

Overview:
- Sequencer and arbiter for the 8x8 life array (four 4x4 tiles).
- Shares the array's single write port, step strobe and readout mux between three requesters: a pattern loader, the generation timer (run / single-step), and the VGA tile reader.
- Guarantees a write and a step never occur in the same cycle.
- Keeps a generation count.

Parameters:
- PERIOD_W, 24, width of the step-period input in clock cycles.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = free-running generations
- single_step  in  1  level; a rising edge requests one generation
- period  in  PERIOD_W  cycles between automatic steps; 0 = no automatic steps
- load_req  in  1  loader request; held until load_ack
- load_tile  in  2  target tile index
- load_data  in  16  tile contents
- load_ack  out  1  one-cycle pulse: tile written this cycle
- rd_req  in  1  reader request; held until rd_ack
- rd_tile  in  2  tile to read
- rd_ack  out  1  one-cycle pulse: rd_data valid
- rd_data  out  16  captured tile contents
- arr_vali  out  16  to array vali
- arr_vali_sel  out  2  to array vali_selector
- arr_write_enb  out  1  to array write_enb
- arr_step  out  1  to array step
- arr_valo_sel  out  2  to array valo_selector
- arr_valo  in  16  from array valo (combinational from arr_valo_sel)
- gen_count  out  GEN_W  generations since last load
- busy  out  1  1 when state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state IDLE.
  - Timer counter cleared; step_pending cleared; single_step edge register cleared.
  - Any in-flight operation is abandoned: no ack is issued after reset releases.
- Registered outputs: every output except busy is driven from flops.
- States: IDLE, LOAD, STEP, READ. LOAD, STEP and READ each last exactly one cycle, then return to IDLE. Sustained throughput is one operation per 2 cycles.
- IDLE arbitration, evaluated each cycle:
  - Priority 1: load_req. Latch load_tile and load_data, go to LOAD.
  - Priority 2: step_pending and rd_req arbitrate round-robin. last_grant flag, reset value = READ, so STEP wins the first tie. The winner goes to STEP or READ.
  - Nothing pending: remain in IDLE.
- LOAD cycle:
  - arr_write_enb=1, arr_vali=latched data, arr_vali_sel=latched tile, load_ack=1.
  - gen_count cleared to 0.
  - step_pending is unaffected; it is served after the load.
- STEP cycle:
  - arr_step=1, arr_write_enb=0.
  - step_pending cleared, unless the timer raises a new request in the same cycle; set wins.
  - gen_count increments, saturating at all-ones.
- READ:
  - On grant, arr_valo_sel=latched rd_tile.
  - In the READ cycle, arr_valo is sampled into rd_data at the end of the cycle and rd_ack=1 on the following cycle. Latency from grant to ack is 2 cycles.
  - arr_valo_sel holds its last value otherwise.
  - rd_data holds until the next read.
- Timer (sub-module):
  - Down-counter runs only while run=1 and period!=0.
  - On reaching 0: sets step_pending and reloads period-1.
  - run falling to 0 freezes the count. A period change takes effect at the next reload.
- Single step: a rising edge of single_step, 1-cycle registered edge detect, sets step_pending in any state, including while run=1.
- step_pending is a single flag. Requests arriving while it is already set are merged, so at most one step is queued.
- Requester contract: load_req/rd_req must stay asserted with stable tile/data until their ack; ack is a single pulse. Violation behaviour is undefined.
- A new request is not accepted in the same cycle as its ack; the next grant is at the earliest 1 cycle later.

Decomposition:
- Package life_sched_pkg:
  - State encoding: IDLE=2'd0, LOAD=2'd1, STEP=2'd2, READ=2'd3.
  - Tile index constants TILE_NW=0, TILE_SW=1, TILE_NE=2, TILE_SE=3, matching the array's selector order.
- Sub-module life_step_timer: period down-counter, single_step edge detect, step_pending flag with set/clear. Inputs: run, period, single_step, clr_pending. Output: step_pending.

Test Plan:
- Reset mid-LOAD (reset low during the LOAD cycle) -> arr_write_enb=0 immediately, no load_ack after release, gen_count=0.
- Four loads (tiles 0-3, data 16'h0000/16'h0660/16'h0000/16'h0000), run=0 -> exactly 4 load_ack pulses, each paired with arr_write_enb=1 and the matching arr_vali_sel/arr_vali; arr_step never asserts.
- run=1, period=10, no other requests -> arr_step pulses every 10 cycles; gen_count=5 after 50 cycles; period=0 -> no further steps.
- load_req and step_pending raised in the same cycle -> LOAD first, STEP 2 cycles later, never both strobes in one cycle; gen_count=1 afterwards.
- run=1, period=1, rd_req held continuously -> grants alternate STEP/READ; rd_ack arrives within 4 cycles; rd_data equals arr_valo for rd_tile.
- single_step toggled 3 times while a load is in progress -> queued requests merge, exactly 1 arr_step after the load completes.
